// File: rtl/data_mem_sequencer.sv
// Purpose: sequences byte/halfword/word MEM-stage accesses onto a byte-wide RAM as little-endian single-byte beats.
// Latency: Stall is high for 1 + N*(WAIT_CYCLES+1) cycles; the load result and Ready appear in the following cycle.
// Backpressure: Stall freezes the pipeline while a request waits or is in flight; requests are latched, so later input changes are ignored.
module data_mem_sequencer #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  ReadWrite,
    input  logic [1:0]            Size,
    input  logic                  SE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  Ready,
    output logic                  Stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wait counter is 3 bits wide, enough for 0..7 idle cycles per beat.
    localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

    state_t                  r_state;
    state_t                  w_state_nxt;

    // Request fields captured when the access is accepted.
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdat;
    logic [1:0]              r_size;
    logic                    r_se;
    logic                    r_rw;

    logic [1:0]              r_beat;
    logic [2:0]              r_wait;
    logic [31:0]             r_res;
    logic [31:0]             r_dout;

    logic [1:0]              w_beat_max;
    logic                    w_last_beat;
    logic                    w_beat_done;
    logic [4:0]              w_lane;
    logic [31:0]             w_res_cap;
    logic [31:0]             w_load_ext;
    logic [31:0]             w_dout_nxt;

    // Last beat index follows the latched size; size 11 behaves as a word.
    assign w_beat_max  = (r_size == 2'b00) ? 2'd0 :
                         (r_size == 2'b01) ? 2'd1 : 2'd3;
    assign w_last_beat = (r_beat == w_beat_max);
    assign w_beat_done = (r_state == BUSY) && (r_wait == LP_WAIT);
    assign w_lane      = {r_beat, 3'b000};

    // Merge the byte currently on the RAM read port into its little-endian lane.
    always_comb begin
        w_res_cap               = r_res;
        w_res_cap[w_lane +: 8]  = mem_rdata;
    end

    // Sign or zero extension of the assembled load according to the latched size.
    always_comb begin
        w_load_ext = w_res_cap;
        case (r_size)
            2'b00:   w_load_ext = {{24{r_se & w_res_cap[7]}},  w_res_cap[7:0]};
            2'b01:   w_load_ext = {{16{r_se & w_res_cap[15]}}, w_res_cap[15:0]};
            default: w_load_ext = w_res_cap;
        endcase
    end

    // Stores report zero so DataOut never carries stale store data.
    assign w_dout_nxt = r_rw ? 32'd0 : w_load_ext;

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE always falls back to IDLE so a held request is not reissued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (Enable) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_beat_done && w_last_beat) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, beat/wait sequencing and load result assembly.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_addr <= '0;
            r_wdat <= '0;
            r_size <= '0;
            r_se   <= 1'b0;
            r_rw   <= 1'b0;
            r_beat <= '0;
            r_wait <= '0;
            r_res  <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Enable) begin
                        r_addr <= Address;
                        r_wdat <= DataIn;
                        r_size <= Size;
                        r_se   <= SE;
                        r_rw   <= ReadWrite;
                        r_beat <= '0;
                        r_wait <= '0;
                        r_res  <= '0;
                    end
                end
                BUSY: begin
                    if (w_beat_done) begin
                        if (!r_rw) begin
                            r_res <= w_res_cap;
                        end
                        if (w_last_beat) begin
                            r_dout <= w_dout_nxt;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                            r_wait <= '0;
                        end
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM port is only driven while a beat is in flight; the write strobe fires on the completing cycle.
    assign mem_addr  = (r_state == BUSY) ? (r_addr + ADDR_WIDTH'(r_beat)) : '0;
    assign mem_wdata = (r_state == BUSY) ? r_wdat[w_lane +: 8] : 8'd0;
    assign mem_we    = w_beat_done && r_rw;

    // A waiting request stalls combinationally in IDLE; Reset overrides everything.
    assign Stall   = !Reset && (((r_state == IDLE) && Enable) || (r_state == BUSY));
    assign Ready   = (r_state == DONE);
    assign DataOut = r_dout;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench: two sequencer instances (no wait states, one wait state) each backed by a 512x8 RAM model.
// Hand-computed expectations for stall length, beat addresses, RAM contents and load results.
// Drives inputs on the falling edge and samples 1 time unit later.
module tb_data_mem_sequencer;

    logic        clk;
    logic        Reset;
    logic        en0, en1;
    logic        ReadWrite;
    logic [1:0]  Size;
    logic        SE;
    logic [8:0]  Address;
    logic [31:0] DataIn;

    logic [31:0] dout0, dout1;
    logic        ready0, ready1, stall0, stall1, we0, we1;
    logic [8:0]  maddr0, maddr1;
    logic [7:0]  wdat0, wdat1, rdat0, rdat1;

    logic [7:0]  ram0 [512];
    logic [7:0]  ram1 [512];

    logic        pl_we, pl_sel;
    logic [8:0]  pl_addr;
    logic [7:0]  pl_dat;

    logic        sel;
    logic        q_stall, q_ready;
    logic [31:0] q_dout;
    logic [8:0]  q_addr;

    int          n_pass, n_total;
    logic [8:0]  addr_log [16];
    int          n_log;

    data_mem_sequencer #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .Reset(Reset), .Enable(en0), .ReadWrite(ReadWrite), .Size(Size), .SE(SE),
        .Address(Address), .DataIn(DataIn), .DataOut(dout0), .Ready(ready0), .Stall(stall0),
        .mem_addr(maddr0), .mem_wdata(wdat0), .mem_we(we0), .mem_rdata(rdat0)
    );

    data_mem_sequencer #(.ADDR_WIDTH(9), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .Reset(Reset), .Enable(en1), .ReadWrite(ReadWrite), .Size(Size), .SE(SE),
        .Address(Address), .DataIn(DataIn), .DataOut(dout1), .Ready(ready1), .Stall(stall1),
        .mem_addr(maddr1), .mem_wdata(wdat1), .mem_we(we1), .mem_rdata(rdat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdat0 = ram0[maddr0];
    assign rdat1 = ram1[maddr1];

    // RAM models: DUT write port plus a bench preload port.
    always @(posedge clk) begin
        if (we0) ram0[maddr0] <= wdat0;
        if (we1) ram1[maddr1] <= wdat1;
        if (pl_we) begin
            if (pl_sel) ram1[pl_addr] <= pl_dat;
            else        ram0[pl_addr] <= pl_dat;
        end
    end

    assign q_stall = sel ? stall1 : stall0;
    assign q_ready = sel ? ready1 : ready0;
    assign q_dout  = sel ? dout1  : dout0;
    assign q_addr  = sel ? maddr1 : maddr0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic poke(input logic s, input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_sel = s; pl_addr = a; pl_dat = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // One access on the selected instance; counts stalled cycles, logs beat addresses, returns DataOut at Ready.
    task automatic run_access(input logic s, input logic rw, input logic [1:0] sz, input logic se,
                              input logic [8:0] a, input logic [31:0] d,
                              output int stalls, output logic [31:0] dout);
        bit got;
        got    = 1'b0;
        stalls = 0;
        dout   = '0;
        n_log  = 0;
        sel    = s;
        @(negedge clk);
        ReadWrite = rw; Size = sz; SE = se; Address = a; DataIn = d;
        if (s) en1 = 1'b1; else en0 = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            #1;
            if (q_stall) begin
                stalls++;
                if (c > 0 && n_log < 16) begin
                    addr_log[n_log] = q_addr;
                    n_log++;
                end
            end
            if (q_ready) begin
                got  = 1'b1;
                dout = q_dout;
                en0  = 1'b0;
                en1  = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        @(negedge clk);
        #1;
        check("ready_one_cycle", {31'd0, q_ready}, 32'd0);
        check("stall_after", {31'd0, q_stall}, 32'd0);
    endtask

    initial begin
        int          st;
        logic [31:0] dv, d1, d2;
        int          nrdy, between, total;

        n_pass = 0; n_total = 0;
        Reset = 1'b0; en0 = 1'b0; en1 = 1'b0;
        ReadWrite = 1'b0; Size = 2'b00; SE = 1'b0; Address = '0; DataIn = '0;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_dat = '0; sel = 1'b0;

        // Reset state, with Enable high to show Stall is forced low.
        #3 Reset = 1'b1;
        en0 = 1'b1;
        @(negedge clk); #1;
        check("rst_stall", {31'd0, stall0}, 32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_dout", dout0, 32'd0);
        check("rst_addr", {23'd0, maddr0}, 32'd0);
        check("rst_we", {31'd0, we0}, 32'd0);
        check("rst_wdata", {24'd0, wdat0}, 32'd0);
        en0 = 1'b0;
        @(negedge clk);
        Reset = 1'b0;

        // Word store, little-endian, 5 stall cycles.
        run_access(1'b0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h11223344, st, dv);
        check("wst_stalls", st, 32'd5);
        check("wst_dout", dv, 32'd0);
        check("wst_b0", {24'd0, ram0[9'h010]}, 32'h44);
        check("wst_b1", {24'd0, ram0[9'h011]}, 32'h33);
        check("wst_b2", {24'd0, ram0[9'h012]}, 32'h22);
        check("wst_b3", {24'd0, ram0[9'h013]}, 32'h11);
        check("wst_addr0", {23'd0, addr_log[0]}, 32'h010);
        check("wst_addr3", {23'd0, addr_log[3]}, 32'h013);

        // Byte loads with sign and zero extension.
        poke(1'b0, 9'h020, 8'h80);
        run_access(1'b0, 1'b0, 2'b00, 1'b1, 9'h020, 32'h0, st, dv);
        check("lb_se_dout", dv, 32'hFFFFFF80);
        check("lb_se_stalls", st, 32'd2);
        run_access(1'b0, 1'b0, 2'b00, 1'b0, 9'h020, 32'h0, st, dv);
        check("lb_ze_dout", dv, 32'h00000080);
        check("lb_ze_stalls", st, 32'd2);

        // Halfword load wrapping past the top of the address space.
        poke(1'b0, 9'h1FF, 8'h34);
        poke(1'b0, 9'h000, 8'h12);
        run_access(1'b0, 1'b0, 2'b01, 1'b0, 9'h1FF, 32'h0, st, dv);
        check("lh_wrap_dout", dv, 32'h00001234);
        check("lh_wrap_stalls", st, 32'd3);
        check("lh_wrap_addr0", {23'd0, addr_log[0]}, 32'h1FF);
        check("lh_wrap_addr1", {23'd0, addr_log[1]}, 32'h000);

        // Halfword load with sign extension from the upper byte.
        poke(1'b0, 9'h030, 8'h01);
        poke(1'b0, 9'h031, 8'h9A);
        run_access(1'b0, 1'b0, 2'b01, 1'b1, 9'h030, 32'h0, st, dv);
        check("lh_se_dout", dv, 32'hFFFF9A01);

        // Reset mid-store after beat 1 has completed.
        poke(1'b0, 9'h040, 8'h00);
        poke(1'b0, 9'h041, 8'h00);
        poke(1'b0, 9'h042, 8'h5A);
        poke(1'b0, 9'h043, 8'h5B);
        sel = 1'b0;
        @(negedge clk);
        ReadWrite = 1'b1; Size = 2'b10; SE = 1'b0; Address = 9'h040; DataIn = 32'hAABBCCDD;
        en0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rstmid_pre_addr", {23'd0, maddr0}, 32'h042);
        Reset = 1'b1;
        en0 = 1'b0;
        #1;
        check("rstmid_stall", {31'd0, stall0}, 32'd0);
        check("rstmid_we", {31'd0, we0}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        nrdy = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ready0) nrdy++;
            @(negedge clk);
        end
        check("rstmid_no_ready", nrdy, 32'd0);
        check("rstmid_b0", {24'd0, ram0[9'h040]}, 32'hDD);
        check("rstmid_b1", {24'd0, ram0[9'h041]}, 32'hCC);
        check("rstmid_b2", {24'd0, ram0[9'h042]}, 32'h5A);
        check("rstmid_b3", {24'd0, ram0[9'h043]}, 32'h5B);

        // Back-to-back word loads with Enable held high.
        for (int i = 0; i < 8; i++) poke(1'b0, 9'h100 + 9'(i), 8'(i + 1));
        sel = 1'b0;
        @(negedge clk);
        ReadWrite = 1'b0; Size = 2'b10; SE = 1'b0; Address = 9'h100;
        en0 = 1'b1;
        nrdy = 0; between = 0; total = 0; d1 = '0; d2 = '0;
        for (int c = 0; c < 40 && nrdy < 2; c++) begin
            #1;
            if (stall0) begin
                total++;
                if (nrdy == 1) between++;
            end
            if (ready0) begin
                nrdy++;
                if (nrdy == 1) begin
                    d1 = dout0;
                    Address = 9'h104;
                end else begin
                    d2 = dout0;
                    en0 = 1'b0;
                end
            end
            @(negedge clk);
        end
        #1;
        check("b2b_ready_count", nrdy, 32'd2);
        check("b2b_total_stalls", total, 32'd10);
        check("b2b_between_stalls", between, 32'd5);
        check("b2b_dout1", d1, 32'h04030201);
        check("b2b_dout2", d2, 32'h08070605);
        check("b2b_ready_after", {31'd0, ready0}, 32'd0);
        check("b2b_stall_after", {31'd0, stall0}, 32'd0);

        // One wait state per beat: word load, then Size 11 on the same data.
        poke(1'b1, 9'h000, 8'h11);
        poke(1'b1, 9'h001, 8'h22);
        poke(1'b1, 9'h002, 8'h33);
        poke(1'b1, 9'h003, 8'h44);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, st, dv);
        check("w1_dout", dv, 32'h44332211);
        check("w1_stalls", st, 32'd9);
        for (int i = 0; i < 8; i++) begin
            check("w1_addr_seq", {23'd0, addr_log[i]}, 32'(i / 2));
        end
        run_access(1'b1, 1'b0, 2'b11, 1'b1, 9'h000, 32'h0, st, dv);
        check("w1_sz11_dout", dv, 32'h44332211);
        check("w1_sz11_stalls", st, 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_sequencer.md
Name: data_mem_sequencer

Overview:
- Sits between the MEM stage and the byte-wide 512x8 data RAM.
- Sequences each byte, halfword or word access as consecutive single-byte RAM beats, little-endian.
- Raises Stall to freeze the pipeline until the access completes; then presents the assembled, sign/zero-extended load result for one cycle.
- Optional wait states per beat support a slower RAM.

Parameters:
ADDR_WIDTH, 9, RAM byte-address width; addresses wrap modulo 2^ADDR_WIDTH.
WAIT_CYCLES, 0, extra idle cycles inserted before each beat completes (0..7).

Ports:
clk  input  1  pipeline clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Enable  input  1  MEM-stage RAM_Enable; request present.
ReadWrite  input  1  0 = load, 1 = store.
Size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
SE  input  1  1 = sign-extend load result, 0 = zero-extend.
Address  input  ADDR_WIDTH  byte address of the least-significant byte.
DataIn  input  32  store data; byte k goes to Address+k.
DataOut  output  32  load result, valid while Ready = 1.
Ready  output  1  one-cycle completion pulse.
Stall  output  1  freeze IF/ID/EX/MEM registers and PC.
mem_addr  output  ADDR_WIDTH  RAM byte address.
mem_wdata  output  8  RAM write byte.
mem_we  output  1  RAM write strobe; the RAM writes on the clk edge while high.
mem_rdata  input  8  RAM read byte, combinational from mem_addr.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- On Reset: state IDLE; DataOut = 0; Ready = 0; Stall = 0 (forced low while Reset is high); mem_addr = 0; mem_wdata = 0; mem_we = 0; beat and wait counters = 0.
- Beat count N: 1 for Size 00, 2 for Size 01, 4 for Size 10 and 11.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Stall = Enable, combinational.
  - At a posedge with Enable = 1: latch Address, DataIn, Size, SE, ReadWrite; beat = 0; wait = 0; go to BUSY.
  - mem_we = 0.
- BUSY:
  - Stall = 1.
  - mem_addr = latched Address + beat, truncated to ADDR_WIDTH (wraps; misaligned accesses allowed).
  - mem_wdata = latched DataIn[8*beat+7 : 8*beat].
  - mem_we = latched ReadWrite && (wait == WAIT_CYCLES).
  - The beat completes at the posedge where wait == WAIT_CYCLES. On completion:
    - For loads, capture mem_rdata into result byte lane `beat`.
    - If beat == N-1, go to DONE; otherwise beat++ and wait = 0.
  - Otherwise wait++.
- DONE:
  - Stall = 0; Ready = 1; mem_we = 0.
  - Load DataOut, byte: {24{SE & b0[7]}, b0}.
  - Load DataOut, halfword: {16{SE & b1[7]}, b1, b0}.
  - Load DataOut, word: {b3, b2, b1, b0}.
  - Store DataOut = 0.
  - The next posedge always returns to IDLE and ignores Enable. The pipeline advances on that same edge, so a held request is never reissued.
- Stall cycles per access = 1 + N*(WAIT_CYCLES+1). The result appears in the cycle after the last stalled cycle.
  - With WAIT_CYCLES = 0: byte 2 stall cycles, halfword 3, word 5.
- Input changes while BUSY are ignored; only latched values are used.
- Reset mid-access: return to IDLE immediately. Bytes already written remain in RAM; no further writes occur; Ready is not pulsed.
- DataOut holds its value outside DONE. Consumers must qualify it with Ready.
- Store bytes written to the RAM are never sign-extended or altered.

Test Plan:
- Word store, Address 0x010, DataIn 0x11223344, W=0 -> RAM[0x010..0x013] = 44, 33, 22, 11; Stall high exactly 5 cycles; Ready pulses once; DataOut = 0.
- Byte load, SE = 1, RAM[0x020] = 0x80 -> DataOut = 0xFFFFFF80 with Ready. Repeated with SE = 0 -> DataOut = 0x00000080; Stall 2 cycles each.
- Halfword load, SE = 0, Address 0x1FF, RAM[0x1FF] = 0x34, RAM[0x000] = 0x12 -> mem_addr sequence 0x1FF, 0x000; DataOut = 0x00001234.
- Word store 0xAABBCCDD at 0x040; Reset asserted after beat 1 completes -> RAM[0x040] = DD, RAM[0x041] = CC, RAM[0x042..0x043] unchanged; Stall = 0 and mem_we = 0 immediately; no Ready pulse.
- Enable held high across two back-to-back word loads (0x100, then 0x104) -> exactly two 4-beat sequences; one Ready per access; one IDLE cycle with Stall high between them.
- WAIT_CYCLES = 1, word load at 0x000 -> each mem_addr held 2 cycles; Stall high 9 cycles; Size 11 behaves identically to Size 10.
